// File: rtl/seq_sub16_nibble.sv
// seq_sub16_nibble: multi-cycle subtractor, DIFF = A - B - BIN, one SLICE-bit
// nibble per clock through a 4-bit carry-lookahead slice. The borrow is held in a
// register between nibbles. Valid/ready handshakes on both the operand and result sides.
module seq_sub16_nibble #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BIN,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] DIFF,
    output logic             BOUT,
    output logic             OVF,
    output logic             ZERO
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  diff_q;
    logic [WIDTH-1:0]  diff_d;
    logic              borrow_q;
    logic [IDXW-1:0]   idx_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              bout_q;
    logic              ovf_q;
    logic              zero_q;

    logic [SLICE-1:0]  aSlice;
    logic [SLICE-1:0]  bSlice;
    logic [SLICE-1:0]  propSlice;
    logic [SLICE-1:0]  genSlice;
    logic [SLICE:0]    carry;
    logic [SLICE-1:0]  sumSlice;
    logic              lookAcc;
    logic              lookProp;
    logic              lastSlice;

    // Select the active nibble and run it through a carry-lookahead slice:
    // subtraction is A + ~B + ~borrow, so the carry-in is the inverted borrow.
    always_comb begin
        aSlice    = '0;
        bSlice    = '0;
        carry     = '0;
        lookAcc   = 1'b0;
        lookProp  = 1'b0;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx_q == IDXW'(i)) begin
                aSlice = a_q[i*SLICE +: SLICE];
                bSlice = b_q[i*SLICE +: SLICE];
            end
        end
        propSlice = aSlice ^ ~bSlice;
        genSlice  = aSlice & ~bSlice;
        carry[0]  = ~borrow_q;
        for (int i = 0; i < SLICE; i++) begin
            lookAcc  = genSlice[i];
            lookProp = propSlice[i];
            for (int j = i - 1; j >= 0; j--) begin
                lookAcc  = lookAcc | (lookProp & genSlice[j]);
                lookProp = lookProp & propSlice[j];
            end
            carry[i+1] = lookAcc | (lookProp & carry[0]);
        end
        sumSlice  = propSlice ^ carry[SLICE-1:0];
        lastSlice = (idx_q == IDXW'(NSLICE - 1));
    end

    // Merge the freshly computed nibble into the result so the flags can see the full word.
    always_comb begin
        diff_d = diff_q;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx_q == IDXW'(i)) begin
                diff_d[i*SLICE +: SLICE] = sumSlice;
            end
        end
    end

    // Control FSM with registered handshake signals, result and flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            bout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= A;
                        b_q        <= B;
                        borrow_q   <= BIN;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    diff_q   <= diff_d;
                    borrow_q <= ~carry[SLICE];
                    idx_q    <= idx_q + IDXW'(1);
                    if (lastSlice) begin
                        bout_q      <= ~carry[SLICE];
                        ovf_q       <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                       (diff_d[WIDTH-1] != a_q[WIDTH-1]);
                        zero_q      <= ~|diff_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign DIFF      = diff_q;
    assign BOUT      = bout_q;
    assign OVF       = ovf_q;
    assign ZERO      = zero_q;

endmodule

// File: tb/tb_seq_sub16_nibble.sv
// tb_seq_sub16_nibble: directed corner cases followed by randomized operations with
// random input delays and output stalls, checked against an arithmetic reference model.
module tb_seq_sub16_nibble;

    localparam int WIDTH = 16;
    localparam int SLICE = 4;
    localparam int NOPS  = 2000;

    typedef struct {
        logic [WIDTH-1:0] diff;
        logic             bout;
        logic             ovf;
        logic             zero;
    } expT;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             BIN;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] DIFF;
    logic             BOUT;
    logic             OVF;
    logic             ZERO;

    int  nVec = 0;
    int  nErr = 0;
    expT scoreboard[$];

    seq_sub16_nibble #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .BIN       (BIN),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .DIFF      (DIFF),
        .BOUT      (BOUT),
        .OVF       (OVF),
        .ZERO      (ZERO)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Hard stop in case some wait escapes its cycle budget.
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference: plain integer subtraction; flags from the word-level rules.
    function automatic expT refModel(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     input logic bin);
        expT r;
        int  full;
        full   = int'(a) - int'(b) - int'(bin);
        r.diff = full[WIDTH-1:0];
        r.bout = (full < 0);
        r.ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (r.diff[WIDTH-1] != a[WIDTH-1]);
        r.zero = (r.diff == '0);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete transaction: optional idle delay, accept, wait for result,
    // optional consumer stall (optionally with ignored in_valid pokes), then handshake.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic bin, input int inDelay, input int stall,
                                 input bit pokeIn);
        expT  e;
        logic wasReady;
        int   budget;
        repeat (inDelay) tick();
        A        = a;
        B        = b;
        BIN      = bin;
        in_valid = 1'b1;
        budget   = 0;
        do begin
            wasReady = in_ready;
            tick();
            budget++;
        end while (!wasReady && budget < 50);
        checkOutput("acceptTimeout", 32'(wasReady), 32'd1);
        in_valid = 1'b0;
        A        = WIDTH'($urandom);
        B        = WIDTH'($urandom);
        BIN      = 1'($urandom);
        scoreboard.push_back(refModel(a, b, bin));
        budget = 0;
        while (!out_valid && budget < 50) begin
            tick();
            budget++;
        end
        checkOutput("doneTimeout", 32'(out_valid), 32'd1);
        e = scoreboard.pop_front();
        checkOutput("diff", 32'(DIFF), 32'(e.diff));
        checkOutput("bout", 32'(BOUT), 32'(e.bout));
        checkOutput("ovf", 32'(OVF), 32'(e.ovf));
        checkOutput("zero", 32'(ZERO), 32'(e.zero));
        for (int s = 0; s < stall; s++) begin
            if (pokeIn) begin
                in_valid = 1'($urandom);
                A        = WIDTH'($urandom);
                B        = WIDTH'($urandom);
            end
            tick();
            checkOutput("stallValid", 32'(out_valid), 32'd1);
            checkOutput("stallDiff", 32'(DIFF), 32'(e.diff));
            checkOutput("stallBout", 32'(BOUT), 32'(e.bout));
            checkOutput("stallInReady", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("singleDone", 32'(out_valid), 32'd0);
        checkOutput("backIdle", 32'(in_ready), 32'd1);
    endtask

    initial begin
        expT e;
        int  k;
        int  budget;
        bit  sawResult;

        // Reset state
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        BIN       = 1'b0;
        repeat (3) tick();
        checkOutput("rstInReady", 32'(in_ready), 32'd1);
        checkOutput("rstOutValid", 32'(out_valid), 32'd0);
        checkOutput("rstDiff", 32'(DIFF), 32'd0);
        checkOutput("rstFlags", {29'd0, BOUT, OVF, ZERO}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Directed corner operations
        applyStimulus(16'h1234, 16'h0034, 1'b0, 0, 0, 1'b0);
        applyStimulus(16'h0000, 16'h0001, 1'b0, 1, 0, 1'b0);
        applyStimulus(16'h8000, 16'h0001, 1'b0, 0, 2, 1'b0);
        applyStimulus(16'h5555, 16'h5554, 1'b1, 0, 0, 1'b0);
        applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, 0, 0, 1'b0);
        applyStimulus(16'h7FFF, 16'hFFFF, 1'b0, 0, 0, 1'b0);

        // Ten-cycle consumer stall with in_valid pokes that must be ignored
        applyStimulus(16'hA5C3, 16'h3C5A, 1'b1, 0, 10, 1'b1);

        // Reset during BUSY slice 2 discards the operation
        A        = 16'h1234;
        B        = 16'h0034;
        BIN      = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("midRstOutValid", 32'(out_valid), 32'd0);
        checkOutput("midRstInReady", 32'(in_ready), 32'd1);
        checkOutput("midRstDiff", 32'(DIFF), 32'd0);
        checkOutput("midRstFlags", {29'd0, BOUT, OVF, ZERO}, 32'd0);
        applyStimulus(16'h0003, 16'h0002, 1'b0, 0, 0, 1'b0);

        // Back-to-back with in_valid and out_ready held high: the handshake edge
        // must not accept, and the issue interval is WIDTH/SLICE+2 cycles.
        e         = refModel(16'h4321, 16'h1234, 1'b1);
        A         = 16'h4321;
        B         = 16'h1234;
        BIN       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        k         = 0;
        sawResult = 1'b0;
        do begin
            tick();
            k++;
            if (out_valid) begin
                sawResult = 1'b1;
                checkOutput("b2bDiff", 32'(DIFF), 32'(e.diff));
            end
        end while (!in_ready && k < 20);
        checkOutput("b2bSawResult", 32'(sawResult), 32'd1);
        checkOutput("b2bIdleAfter", k, (WIDTH / SLICE) + 1);
        tick();
        checkOutput("b2bAccepted", 32'(in_ready), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        budget    = 0;
        while (!out_valid && budget < 50) begin
            tick();
            budget++;
        end
        checkOutput("b2bSecondDone", 32'(out_valid), 32'd1);
        checkOutput("b2bSecondDiff", 32'(DIFF), 32'(e.diff));
        checkOutput("b2bSecondBout", 32'(BOUT), 32'(e.bout));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("b2bSingle", 32'(out_valid), 32'd0);

        // Randomized operations with random input delays and output stalls
        for (int n = 0; n < NOPS; n++) begin
            applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
                          $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
        end
        checkOutput("scoreboardEmpty", 32'(scoreboard.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
